// File: rtl/cu_pkg.sv
// Shared definitions for the multi-cycle control unit: FSM states, opcodes,
// control-word layout, ALU function codes and branch condition codes.
package cu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_MOVI = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_SL   = 4'h7;
    localparam logic [3:0] OP_SR   = 4'h8;
    localparam logic [3:0] OP_LD   = 4'h9;
    localparam logic [3:0] OP_ST   = 4'hA;
    localparam logic [3:0] OP_B    = 4'hB;
    localparam logic [3:0] OP_BR   = 4'hC;
    localparam logic [3:0] OP_BCC  = 4'hD;
    localparam logic [3:0] OP_PCST = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int CW_WIDTH  = 22;
    localparam int CW_SL     = 21;
    localparam int CW_IL     = 20;
    localparam int CW_PCL    = 19;
    localparam int CW_MR     = 18;
    localparam int CW_MW     = 17;
    localparam int CW_B_SEL  = 16;
    localparam int CW_A_SEL  = 15;
    localparam int CW_EN_ALU = 14;
    localparam int CW_CI     = 13;
    localparam int CW_FS_LSB = 10;
    localparam int CW_W      = 9;
    localparam int CW_SB_LSB = 6;
    localparam int CW_SA_LSB = 3;
    localparam int CW_DA_LSB = 0;

    // Field order matches the bit positions above, MSB first.
    typedef struct packed {
        logic       sl;
        logic       il;
        logic       pcl;
        logic       mr;
        logic       mw;
        logic       b_sel;
        logic       a_sel;
        logic       en_alu;
        logic       ci;
        logic [2:0] fs;
        logic       w;
        logic [2:0] sb;
        logic [2:0] sa;
        logic [2:0] da;
    } cw_t;

    localparam logic [2:0] FS_AND = 3'b000;
    localparam logic [2:0] FS_OR  = 3'b001;
    localparam logic [2:0] FS_ADD = 3'b010;
    localparam logic [2:0] FS_SUB = 3'b011;
    localparam logic [2:0] FS_SL  = 3'b100;
    localparam logic [2:0] FS_SR  = 3'b101;
    localparam logic [2:0] FS_XOR = 3'b110;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;

    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    function automatic logic cond_met(input logic [3:0] cond, input logic [3:0] flags);
        case (cond)
            COND_EQ: cond_met = flags[FLAG_Z];
            COND_NE: cond_met = ~flags[FLAG_Z];
            COND_CS: cond_met = flags[FLAG_C];
            COND_CC: cond_met = ~flags[FLAG_C];
            COND_MI: cond_met = flags[FLAG_N];
            COND_PL: cond_met = ~flags[FLAG_N];
            default: cond_met = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational EXEC-state decoder: instruction + ALU flags -> control word, K, is_halt.
// Conditional branches are decoded only when CU_BRANCH_COND_EN is defined.
module cu_decode
    import cu_pkg::*;
(
    input  logic [15:0] I,
    input  logic [3:0]  alu_status,
    output logic [21:0] control_word,
    output logic [7:0]  K,
    output logic        is_halt
);

    cw_t  w_cw;
    logic w_bcc_taken;

`ifdef CU_BRANCH_COND_EN
    assign w_bcc_taken = cond_met(I[11:8], alu_status);
`else
    logic w_unused_status;
    assign w_unused_status = ^alu_status;
    assign w_bcc_taken     = 1'b0;
`endif

    always_comb begin
        w_cw    = '0;
        K       = '0;
        is_halt = 1'b0;
        case (I[15:12])
            OP_MOVI: begin
                w_cw.b_sel  = 1'b1;
                w_cw.en_alu = 1'b1;
                w_cw.fs     = FS_OR;
                w_cw.w      = 1'b1;
                w_cw.sa     = 3'b111;
                w_cw.da     = I[10:8];
                K           = I[7:0];
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SL, OP_SR: begin
                w_cw.en_alu = 1'b1;
                w_cw.w      = 1'b1;
                w_cw.sl     = I[11];
                w_cw.da     = I[10:8];
                w_cw.sa     = I[7:5];
                w_cw.sb     = I[4:2];
                w_cw.ci     = (I[15:12] == OP_SUB);
                case (I[15:12])
                    OP_ADD:  w_cw.fs = FS_ADD;
                    OP_SUB:  w_cw.fs = FS_SUB;
                    OP_AND:  w_cw.fs = FS_AND;
                    OP_OR:   w_cw.fs = FS_OR;
                    OP_XOR:  w_cw.fs = FS_XOR;
                    OP_SL:   w_cw.fs = FS_SL;
                    default: w_cw.fs = FS_SR;
                endcase
            end
            OP_LD: begin
                w_cw.mr = 1'b1;
                w_cw.w  = 1'b1;
                w_cw.da = I[10:8];
                K       = I[7:0];
            end
            OP_ST: begin
                w_cw.mw     = 1'b1;
                w_cw.en_alu = 1'b1;
                w_cw.fs     = FS_OR;
                w_cw.sb     = 3'b111;
                w_cw.sa     = I[10:8];
                K           = I[7:0];
            end
            OP_B, OP_BCC: begin
                // Relative branch: PC + K + 1 with the B input selecting K.
                if (I[15:12] == OP_B || w_bcc_taken) begin
                    w_cw.pcl    = 1'b1;
                    w_cw.b_sel  = 1'b1;
                    w_cw.a_sel  = 1'b1;
                    w_cw.en_alu = 1'b1;
                    w_cw.ci     = 1'b1;
                    w_cw.fs     = FS_ADD;
                    K           = I[7:0];
                end
            end
            OP_BR: begin
                w_cw.pcl    = 1'b1;
                w_cw.en_alu = 1'b1;
                w_cw.fs     = FS_OR;
                w_cw.sb     = 3'b111;
                w_cw.sa     = I[10:8];
            end
            OP_PCST: begin
                w_cw.a_sel  = 1'b1;
                w_cw.en_alu = 1'b1;
                w_cw.ci     = 1'b1;
                w_cw.fs     = FS_ADD;
                w_cw.w      = 1'b1;
                w_cw.sb     = 3'b111;
                w_cw.da     = I[10:8];
            end
            OP_HALT: is_halt = 1'b1;
            default: ;
        endcase
    end

    assign control_word = w_cw;

endmodule

// File: rtl/control_unit_mi.sv
// Multi-cycle control unit: IDLE/FETCH/EXEC/HALT FSM, output muxing and retired counter.
// Optional conditional branching via CU_BRANCH_COND_EN (see cu_decode).
module control_unit_mi
    import cu_pkg::*;
#(
    parameter int RETIRED_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [15:0]          I,
    input  logic [3:0]           alu_status,
    output logic [21:0]          control_word,
    output logic [7:0]           K,
    output logic                 halted,
    output logic [RETIRED_W-1:0] retired
);

    state_t               r_state;
    state_t               w_state_next;
    logic [RETIRED_W-1:0] r_retired;
    logic [21:0]          w_exec_cw;
    logic [7:0]           w_exec_k;
    logic                 w_exec_halt;
    cw_t                  w_fetch_cw;

    cu_decode u_decode (
        .I            (I),
        .alu_status   (alu_status),
        .control_word (w_exec_cw),
        .K            (w_exec_k),
        .is_halt      (w_exec_halt)
    );

    // PC <= PC + 0 + 1 with R7 on the B bus reading as zero, while the IR loads.
    always_comb begin
        w_fetch_cw        = '0;
        w_fetch_cw.il     = 1'b1;
        w_fetch_cw.pcl    = 1'b1;
        w_fetch_cw.a_sel  = 1'b1;
        w_fetch_cw.en_alu = 1'b1;
        w_fetch_cw.ci     = 1'b1;
        w_fetch_cw.fs     = FS_ADD;
        w_fetch_cw.sb     = 3'b111;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        control_word = '0;
        K            = '0;
        halted       = 1'b0;
        case (r_state)
            ST_IDLE: w_state_next = ST_FETCH;
            ST_FETCH: begin
                control_word = w_fetch_cw;
                w_state_next = ST_EXEC;
            end
            ST_EXEC: begin
                control_word = w_exec_cw;
                K            = w_exec_k;
                w_state_next = w_exec_halt ? ST_HALT : ST_FETCH;
            end
            ST_HALT: halted = 1'b1;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Every EXEC cycle leaves EXEC, so it retires exactly one instruction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_retired <= '0;
        end else if (r_state == ST_EXEC) begin
            r_retired <= r_retired + RETIRED_W'(1);
        end
    end

    assign retired = r_retired;

endmodule

// File: tb/tb_control_unit_mi.sv
// Scoreboard bench for control_unit_mi: directed instruction stream, expectations
// queued per cycle and checked by an independent negedge monitor.
module tb_control_unit_mi;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] I = '0;
    logic [3:0]  alu_status = '0;
    logic [21:0] control_word;
    logic [7:0]  K;
    logic        halted;
    logic [15:0] retired;

    control_unit_mi #(.RETIRED_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .I            (I),
        .alu_status   (alu_status),
        .control_word (control_word),
        .K            (K),
        .halted       (halted),
        .retired      (retired)
    );

    always #5 clk = ~clk;

`ifdef CU_BRANCH_COND_EN
    localparam bit BR_EN = 1'b1;
`else
    localparam bit BR_EN = 1'b0;
`endif

    localparam logic [21:0] CW_FETCH = 22'b0_1_1_0_0_0_1_1_1_010_0_111_000_000;
    localparam logic [21:0] CW_MOVI  = 22'b0_0_0_0_0_1_0_1_0_001_1_000_111_011;
    localparam logic [21:0] CW_SUB   = 22'b1_0_0_0_0_0_0_1_1_011_1_001_000_010;
    localparam logic [21:0] CW_BRANCH= 22'b0_0_1_0_0_1_1_1_1_010_0_000_000_000;
    localparam logic [21:0] CW_ADD   = 22'b0_0_0_0_0_0_0_1_0_010_1_010_001_001;
    localparam logic [21:0] CW_XOR   = 22'b1_0_0_0_0_0_0_1_0_110_1_111_010_111;
    localparam logic [21:0] CW_LD    = 22'b0_0_0_1_0_0_0_0_0_000_1_000_000_010;
    localparam logic [21:0] CW_ST    = 22'b0_0_0_0_1_0_0_1_0_001_0_111_011_000;
    localparam logic [21:0] CW_BR    = 22'b0_0_1_0_0_0_0_1_0_001_0_111_101_000;
    localparam logic [21:0] CW_PCST  = 22'b0_0_0_0_0_0_1_1_1_010_1_111_000_100;

    typedef struct {
        int          cyc;
        string       name;
        logic [21:0] cw;
        logic [7:0]  k;
        logic        h;
        logic [15:0] ret;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            checks++;
            if (e.cyc != cyc) begin
                failures++;
                $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)", e.name, e.cyc, cyc);
            end else if (control_word !== e.cw || K !== e.k || halted !== e.h || retired !== e.ret) begin
                failures++;
                $display("FAIL %s: got cw=%b K=%h halted=%b retired=%0d, want cw=%b K=%h halted=%b retired=%0d",
                         e.name, control_word, K, halted, retired, e.cw, e.k, e.h, e.ret);
            end else begin
                $display("ok   %s: cw=%b K=%h halted=%b retired=%0d", e.name, control_word, K, halted, retired);
            end
        end
    end

    task automatic push(input string name, input logic [21:0] cw, input logic [7:0] k,
                        input logic h, input logic [15:0] ret);
        exp_t e;
        e.cyc = cyc; e.name = name; e.cw = cw; e.k = k; e.h = h; e.ret = ret;
        sb_q.push_back(e);
    endtask

    task automatic step(input string name, input logic [15:0] instr, input logic [3:0] st,
                        input logic [21:0] cw, input logic [7:0] k, input logic h,
                        input logic [15:0] ret);
        @(posedge clk); #1;
        I = instr;
        alu_status = st;
        push(name, cw, k, h, ret);
    endtask

    // One FETCH cycle followed by the EXEC cycle of instr.
    task automatic instr_run(input string name, input logic [15:0] instr, input logic [3:0] st,
                             input logic [21:0] cw, input logic [7:0] k, input logic [15:0] ret);
        step({name, "_fetch"}, instr, st, CW_FETCH, 8'h00, 1'b0, ret);
        step(name, instr, st, cw, k, 1'b0, ret);
    endtask

    // Two cycles with rst low, then release mid-cycle so the IDLE cycle is also checked.
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        push("reset0", '0, '0, 1'b0, '0);
        @(posedge clk); #1;
        push("reset1_idle", '0, '0, 1'b0, '0);
        #1 rst = 1'b1;
    endtask

    initial begin : stimulus
        #200000;
        $display("FAIL watchdog: time limit reached with %0d expectations pending", sb_q.size());
        $fatal(1, "watchdog");
    end

    initial begin : driver
        do_reset();
        instr_run("movi",     16'h1304, 4'b0000, CW_MOVI, 8'd4, 16'd0);
        instr_run("sub_s1",   16'h3A04, 4'b0000, CW_SUB, 8'd0, 16'd1);
        instr_run("bcc_eq_z1",16'hD005, 4'b0001, BR_EN ? CW_BRANCH : 22'd0, BR_EN ? 8'd5 : 8'd0, 16'd2);
        instr_run("bcc_eq_z0",16'hD005, 4'b0000, 22'd0, 8'd0, 16'd3);
        instr_run("bcc_ne_z0",16'hD107, 4'b0000, BR_EN ? CW_BRANCH : 22'd0, BR_EN ? 8'd7 : 8'd0, 16'd4);
        instr_run("add",      16'h2128, 4'b0000, CW_ADD, 8'd0, 16'd5);
        instr_run("xor_s1",   16'h6F5C, 4'b0000, CW_XOR, 8'd0, 16'd6);
        instr_run("ld",       16'h9210, 4'b0000, CW_LD, 8'h10, 16'd7);
        instr_run("st",       16'hA320, 4'b0000, CW_ST, 8'h20, 16'd8);
        instr_run("br",       16'hC500, 4'b0000, CW_BR, 8'd0, 16'd9);
        instr_run("pcst",     16'hE400, 4'b0000, CW_PCST, 8'd0, 16'd10);
        instr_run("b",        16'hB0FE, 4'b0000, CW_BRANCH, 8'hFE, 16'd11);
        step("fetch_after_b", 16'h0000, 4'b0000, CW_FETCH, 8'd0, 1'b0, 16'd12);

        // Halt sequence from a fresh reset.
        do_reset();
        instr_run("nop0", 16'h0000, 4'b0000, 22'd0, 8'd0, 16'd0);
        instr_run("nop1", 16'h0000, 4'b0000, 22'd0, 8'd0, 16'd1);
        instr_run("nop2", 16'h0000, 4'b0000, 22'd0, 8'd0, 16'd2);
        instr_run("halt", 16'hF000, 4'b0000, 22'd0, 8'd0, 16'd3);
        for (int n = 0; n < 10; n++) begin
            step($sformatf("halted%0d", n), 16'h1304, 4'b1111, 22'd0, 8'd0, 1'b1, 16'd4);
        end

        // Reset dropped in the middle of an ADD's EXEC cycle.
        do_reset();
        step("midrst_fetch", 16'h2128, 4'b0000, CW_FETCH, 8'd0, 1'b0, 16'd0);
        @(posedge clk); #1;
        #1 rst = 1'b0;
        push("midrst_exec", 22'd0, 8'd0, 1'b0, 16'd0);
        @(posedge clk); #1;
        push("midrst_hold", 22'd0, 8'd0, 1'b0, 16'd0);
        #1 rst = 1'b1;
        step("midrst_release_fetch", 16'h2128, 4'b0000, CW_FETCH, 8'd0, 1'b0, 16'd0);
        step("midrst_add", 16'h2128, 4'b0000, CW_ADD, 8'd0, 1'b0, 16'd0);
        step("midrst_retired", 16'h0000, 4'b0000, CW_FETCH, 8'd0, 1'b0, 16'd1);

        @(posedge clk);
        @(negedge clk);
        #1;
        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            checks++;
            failures++;
            $display("FAIL %s: never checked, still queued for cycle %0d", e.name, e.cyc);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
